dot_product_mac: RTL

DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

---
 rtl/dot_product_pkg.sv | 14 +
 rtl/dot_product_lanes.sv | 33 +++
 rtl/dot_product_mac.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product MAC.
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  function automatic int default_res_w(input int width, input int n);
    return 2 * width + $clog2(n) + 4;
  endfunction

endpackage

// File: rtl/dot_product_lanes.sv
// Combinational sum of P element products for one chunk, extended to SUM_W bits.
module dot_product_lanes #(
  parameter int WIDTH  = 8,
  parameter int P      = 2,
  parameter int SIGNED = 0,
  parameter int SUM_W  = 24
) (
  input  logic [WIDTH*P-1:0] a_chunk,
  input  logic [WIDTH*P-1:0] b_chunk,
  output logic [SUM_W-1:0]   sum
);

  logic [SUM_W-1:0] ea;
  logic [SUM_W-1:0] eb;

  // Operands are widened before multiplying so the truncated product is exact mod 2^SUM_W.
  always_comb begin
    sum = '0;
    ea  = '0;
    eb  = '0;
    for (int unsigned i = 0; i < P; i++) begin
      if (SIGNED != 0) begin
        ea = SUM_W'($signed(a_chunk[i*WIDTH +: WIDTH]));
        eb = SUM_W'($signed(b_chunk[i*WIDTH +: WIDTH]));
      end else begin
        ea = SUM_W'(a_chunk[i*WIDTH +: WIDTH]);
        eb = SUM_W'(b_chunk[i*WIDTH +: WIDTH]);
      end
      sum = sum + ea * eb;
    end
  end

endmodule

// File: rtl/dot_product_mac.sv
// Multi-cycle dot-product MAC with optional accumulation onto the last delivered result.
// Define DOT_PRODUCT_MAC_SAT_EN to saturate on accumulator overflow and report out_ovf.
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N      = 4,
  parameter int P      = 2,
  parameter int SIGNED = 0,
  parameter int RES_W  = default_res_w(WIDTH, N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*N-1:0]   A_vec,
  input  logic [WIDTH*N-1:0]   B_vec,
  input  logic                 in_acc,
  output logic [RES_W-1:0]     result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_ovf
);

  if (N % P != 0) begin : g_bad_lanes
    $error("dot_product_mac: N must be a multiple of P");
  end

  localparam int CHUNKS = N / P;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
`ifdef DOT_PRODUCT_MAC_SAT_EN
  localparam int SUM_W  = RES_W + 1;
`else
  localparam int SUM_W  = RES_W;
`endif

  state_t               state;
  state_t               next_state;
  logic [CW-1:0]        cnt;
  logic                 last_chunk;
  logic [WIDTH*N-1:0]   a_q;
  logic [WIDTH*N-1:0]   b_q;
  logic [RES_W-1:0]     acc;
  logic [RES_W-1:0]     acc_next;
  logic [RES_W-1:0]     last_res;
  logic [SUM_W-1:0]     lane_sum;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == HOLD);
  assign result     = acc;
  assign last_chunk = (cnt == CW'(CHUNKS - 1));

  dot_product_lanes #(
    .WIDTH  (WIDTH),
    .P      (P),
    .SIGNED (SIGNED),
    .SUM_W  (SUM_W)
  ) u_lanes (
    .a_chunk (a_q[cnt*P*WIDTH +: P*WIDTH]),
    .b_chunk (b_q[cnt*P*WIDTH +: P*WIDTH]),
    .sum     (lane_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)   next_state = BUSY;
      BUSY:    if (last_chunk) next_state = HOLD;
      HOLD:    if (out_ready)  next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

`ifdef DOT_PRODUCT_MAC_SAT_EN
  logic [SUM_W-1:0] acc_ext;
  logic [SUM_W-1:0] total;
  logic             step_ovf;
  logic             ovf_q;

  // One guard bit above RES_W exposes unsigned carry-out or signed sign disagreement.
  always_comb begin
    acc_ext  = (SIGNED != 0) ? {acc[RES_W-1], acc} : {1'b0, acc};
    total    = acc_ext + lane_sum;
    step_ovf = 1'b0;
    acc_next = total[RES_W-1:0];
    if (SIGNED != 0) begin
      if (total[RES_W] != total[RES_W-1]) begin
        step_ovf = 1'b1;
        acc_next = total[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
      end
    end else if (total[RES_W]) begin
      step_ovf = 1'b1;
      acc_next = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf_q <= 1'b0;
    end else if (state == BUSY) begin
      ovf_q <= ovf_q | step_ovf;
    end
  end

  assign out_ovf = ovf_q;
`else
  always_comb begin
    acc_next = acc + lane_sum;
  end

  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      acc      <= '0;
      last_res <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= A_vec;
            b_q <= B_vec;
            cnt <= '0;
            acc <= in_acc ? last_res : '0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        HOLD: begin
          if (out_ready) last_res <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule
